// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner
//   Front-end for the irrigation controller. Six raw field sensor pins are
//   synchronised, sampled on a slow prescaler tick and debounced, so the
//   downstream level/irrigation logic only ever sees stable values. A small
//   FSM flags a persistent physically impossible tank-level combination, and
//   a strobe marks every cycle in which a filtered value has just changed.
//
// Ports
//   clk            system clock (single domain)
//   reiniciar      asynchronous active-high reset
//   H_raw..T_raw   raw sensor pins, asynchronous to clk
//   H,M,L,Ua,Us,T  filtered, registered sensor values
//   level_fault    registered, high only while the fault FSM is in FAULT
//   change_pulse   one-cycle strobe, first cycle a new filtered value shows
//   sample_tick    one-cycle strobe per sample instant
//
// Fault FSM
//   state      | meaning
//   ST_OK      | level combination valid
//   ST_SUSPECT | invalid combination seen, counting consecutive invalid ticks
//   ST_FAULT   | fault declared, counting consecutive valid ticks to recover
module sensor_input_conditioner #(
    parameter int SAMPLE_DIV       = 50000,
    parameter int DEBOUNCE_SAMPLES = 8,
    parameter int ERR_SAMPLES      = 16
) (
    input  logic clk,
    input  logic reiniciar,
    input  logic H_raw,
    input  logic M_raw,
    input  logic L_raw,
    input  logic Ua_raw,
    input  logic Us_raw,
    input  logic T_raw,
    output logic H,
    output logic M,
    output logic L,
    output logic Ua,
    output logic Us,
    output logic T,
    output logic level_fault,
    output logic change_pulse,
    output logic sample_tick
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
    localparam int ERR_W = $clog2(ERR_SAMPLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SAMPLES - 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // channel order: {T, Us, Ua, L, M, H}
    logic [5:0]            w_raw;
    logic [5:0]            r_sync1;
    logic [5:0]            r_sync2;
    logic [5:0]            r_filt;
    logic [5:0]            w_filt_next;
    logic [5:0]            w_upd;
    logic [5:0][DB_W-1:0]  r_db_cnt;
    logic [5:0][DB_W-1:0]  w_db_next;

    logic [DIV_W-1:0]      r_div_cnt;
    logic [DIV_W-1:0]      w_div_next;
    logic                  r_tick;

    state_t                r_state;
    state_t                w_state_next;
    logic [ERR_W-1:0]      r_err_cnt;
    logic [ERR_W-1:0]      w_err_next;
    logic                  w_invalid;
    logic                  r_fault;
    logic                  r_change;

    assign w_raw = {T_raw, Us_raw, Ua_raw, L_raw, M_raw, H_raw};

    // Prescaler. The tick is registered from the next count so it lines up
    // with the cycle in which the counter sits at SAMPLE_DIV-1, yet stays 0
    // while reset is held (matters for SAMPLE_DIV=1).
    always_comb begin
        w_div_next = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end

    // Debounce: a new level is accepted only after DEBOUNCE_SAMPLES
    // consecutive differing samples; any matching sample discards the count.
    always_comb begin
        w_filt_next = r_filt;
        w_db_next   = r_db_cnt;
        w_upd       = '0;
        if (r_tick) begin
            for (int i = 0; i < 6; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    w_db_next[i] = '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    w_filt_next[i] = r_sync2[i];
                    w_db_next[i]   = '0;
                    w_upd[i]       = 1'b1;
                end else begin
                    w_db_next[i] = r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // H without M, or M without L, cannot happen with a real liquid column.
    assign w_invalid = (r_filt[0] & ~r_filt[1]) | (r_filt[1] & ~r_filt[2]);

    // Counter compares against ERR_SAMPLES-1 before incrementing, so with
    // ERR_SAMPLES=1 the OK branch goes straight to FAULT.
    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err_cnt;
        if (r_tick) begin
            case (r_state)
                ST_OK: begin
                    if (w_invalid) begin
                        if (r_err_cnt == ERR_LAST) begin
                            w_state_next = ST_FAULT;
                            w_err_next   = '0;
                        end else begin
                            w_state_next = ST_SUSPECT;
                            w_err_next   = r_err_cnt + 1'b1;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!w_invalid) begin
                        w_state_next = ST_OK;
                        w_err_next   = '0;
                    end else if (r_err_cnt == ERR_LAST) begin
                        w_state_next = ST_FAULT;
                        w_err_next   = '0;
                    end else begin
                        w_err_next = r_err_cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (w_invalid) begin
                        w_err_next = '0;
                    end else if (r_err_cnt == ERR_LAST) begin
                        w_state_next = ST_OK;
                        w_err_next   = '0;
                    end else begin
                        w_err_next = r_err_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_OK;
                    w_err_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reiniciar) begin
        if (reiniciar) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_filt    <= '0;
            r_db_cnt  <= '0;
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
            r_state   <= ST_OK;
            r_err_cnt <= '0;
            r_fault   <= 1'b0;
            r_change  <= 1'b0;
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_filt    <= w_filt_next;
            r_db_cnt  <= w_db_next;
            r_div_cnt <= w_div_next;
            r_tick    <= (w_div_next == DIV_LAST);
            r_state   <= w_state_next;
            r_err_cnt <= w_err_next;
            r_fault   <= (w_state_next == ST_FAULT);
            r_change  <= |w_upd;
        end
    end

    assign H            = r_filt[0];
    assign M            = r_filt[1];
    assign L            = r_filt[2];
    assign Ua           = r_filt[3];
    assign Us           = r_filt[4];
    assign T            = r_filt[5];
    assign level_fault  = r_fault;
    assign change_pulse = r_change;
    assign sample_tick  = r_tick;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
module tb_sensor_input_conditioner;

    logic       clk;
    logic       rst;
    // channel order in every vector: {T, Us, Ua, L, M, H}
    logic [5:0] ra, rb, rc;
    logic [5:0] oa, ob, oc;
    logic       fa, fb, fc;
    logic       ca, cb, cc;
    logic       ta, tb, tc;

    int n_total = 0;
    int n_bad   = 0;

    // A: fast sampling, 4-sample debounce
    sensor_input_conditioner #(.SAMPLE_DIV(1), .DEBOUNCE_SAMPLES(4), .ERR_SAMPLES(16)) u_a (
        .clk(clk), .reiniciar(rst),
        .H_raw(ra[0]), .M_raw(ra[1]), .L_raw(ra[2]), .Ua_raw(ra[3]), .Us_raw(ra[4]), .T_raw(ra[5]),
        .H(oa[0]), .M(oa[1]), .L(oa[2]), .Ua(oa[3]), .Us(oa[4]), .T(oa[5]),
        .level_fault(fa), .change_pulse(ca), .sample_tick(ta));

    // B: prescaled sampling
    sensor_input_conditioner #(.SAMPLE_DIV(5), .DEBOUNCE_SAMPLES(2), .ERR_SAMPLES(16)) u_b (
        .clk(clk), .reiniciar(rst),
        .H_raw(rb[0]), .M_raw(rb[1]), .L_raw(rb[2]), .Ua_raw(rb[3]), .Us_raw(rb[4]), .T_raw(rb[5]),
        .H(ob[0]), .M(ob[1]), .L(ob[2]), .Ua(ob[3]), .Us(ob[4]), .T(ob[5]),
        .level_fault(fb), .change_pulse(cb), .sample_tick(tb));

    // C: no debounce, short fault window
    sensor_input_conditioner #(.SAMPLE_DIV(1), .DEBOUNCE_SAMPLES(1), .ERR_SAMPLES(3)) u_c (
        .clk(clk), .reiniciar(rst),
        .H_raw(rc[0]), .M_raw(rc[1]), .L_raw(rc[2]), .Ua_raw(rc[3]), .Us_raw(rc[4]), .T_raw(rc[5]),
        .H(oc[0]), .M(oc[1]), .L(oc[2]), .Ua(oc[3]), .Us(oc[4]), .T(oc[5]),
        .level_fault(fc), .change_pulse(cc), .sample_tick(tc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:21] hpat;
        logic [0:21] fexp;
        int np, nf;
        logic found;

        ra = '0; rb = '0; rc = '0; rst = 1'b1;
        repeat (3) step();

        // reset values
        chk("rst_a", {oa, fa, ca, ta}, 0);
        chk("rst_b", {ob, fb, cb, tb}, 0);
        chk("rst_c", {oc, fc, cc, tc}, 0);

        #2 rst = 1'b0;
        step();
        chk("tick_a_const", ta, 1);
        step();
        chk("tick_c_const", tc, 1);

        // single channel latency: L visible after edge k+5
        ra[2] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("p1_L", oa[2], (i >= 6) ? 1 : 0);
            chk("p1_chg", ca, (i == 6) ? 1 : 0);
            chk("p1_HM", oa[1:0], 0);
        end

        // glitch of 3 samples is rejected
        np = 0;
        for (int i = 0; i < 14; i++) begin
            ra[4] = (i < 3);
            step();
            np += int'(ca);
        end
        chk("p2_glitch_Us", oa[4], 0);
        chk("p2_glitch_chg", np, 0);

        ra[4] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 5) chk("p2_Us_early", oa[4], 0);
            if (i == 6) begin
                chk("p2_Us", oa[4], 1);
                chk("p2_Us_chg", ca, 1);
            end
        end

        // prescaler period and prescaled debounce latency
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (tb) found = 1'b1;
        end
        chk("p3_tick_found", found, 1);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("p3_tick_period", tb, ((i % 5) == 0) ? 1 : 0);
        end
        rb[5] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 10) chk("p3_T_early", ob[5], 0);
            if (i == 11) begin
                chk("p3_T", ob[5], 1);
                chk("p3_T_chg", cb, 1);
            end
            if (i == 12) chk("p3_T_chg_end", cb, 0);
        end

        // fault entry/exit on C; H raw pattern reaches the FSM 4 edges later
        rc[2] = 1'b1;
        repeat (4) step();
        hpat = 22'b1101100111100100000000;
        fexp = 22'b0000000000001111111000;
        for (int i = 0; i < 22; i++) begin
            rc[0] = hpat[i];
            step();
            chk($sformatf("p4_fault_%0d", i), fc, fexp[i]);
        end

        // async reset while A is mid-debounce and C is in FAULT
        rc[0] = 1'b1;
        repeat (4) step();
        ra[3] = 1'b1;
        repeat (2) step();
        chk("p6_pre_fault", fc, 1);
        chk("p6_pre_Ua", oa[3], 0);
        #2 rst = 1'b1;
        #1;
        chk("p6_async_a", oa, 0);
        chk("p6_async_fault", fc, 0);
        chk("p6_async_c", oc, 0);
        step();
        step();
        #2 rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) chk("p6_redeb_early", oa, 0);
            if (i == 6) begin
                chk("p6_redeb", oa, 6'b011100);
                chk("p6_redeb_chg", ca, 1);
            end
        end

        // simultaneous H/M/L rise: one pulse, no fault
        ra = '0;
        repeat (8) step();
        chk("p5_clear", oa, 0);
        ra[2:0] = 3'b111;
        np = 0;
        nf = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            np += int'(ca);
            nf += int'(fa);
            if (i == 5) chk("p5_hml_early", oa[2:0], 0);
            if (i == 6) chk("p5_hml", oa[2:0], 3'b111);
        end
        chk("p5_one_pulse", np, 1);
        chk("p5_no_fault", nf, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sensor_input_conditioner.md
Name: sensor_input_conditioner

Overview:
- Upstream front-end for the irrigation top level; sits between the six raw field sensor pins and the irrigation and level logic.
- Sensor pins: tank levels H/M/L, air humidity Ua, soil humidity Us, temperature T.
- Per channel: synchronises, samples at a slow tick and debounces, so downstream logic sees only stable levels.
- Also flags a persistent physically-impossible tank-level combination and pulses whenever any filtered value changes.

Parameters:
- SAMPLE_DIV, 50000, clk cycles per sample tick (1 = every cycle); legal range ≥1.
- DEBOUNCE_SAMPLES, 8, consecutive differing samples needed to accept a new value; legal range ≥1.
- ERR_SAMPLES, 16, consecutive samples needed to enter and to leave the level fault; legal range ≥1.

Ports:
- clk  in  1  system clock, single clock domain
- reiniciar  in  1  asynchronous active-high reset
- H_raw, M_raw, L_raw  in  1 each  raw level probes, asynchronous to clk
- Ua_raw, Us_raw, T_raw  in  1 each  raw climate sensors, asynchronous to clk
- H, M, L, Ua, Us, T  out  1 each  filtered, registered sensor values
- level_fault  out  1  persistent invalid level combination
- change_pulse  out  1  one-cycle strobe: some filtered output changed
- sample_tick  out  1  one-cycle strobe per sample instant (debug/aux)

Behaviour:
- Interface: one clock, clk. Reset reiniciar is asynchronous and active-high.
- Reset: all filtered outputs 0 (empty tank, dry, cold); level_fault, change_pulse and sample_tick 0; all counters and synchroniser flops 0; fault FSM in OK.
- Synchroniser: each raw input passes through a 2-flop synchroniser. s_x denotes the second-stage value.
- Prescaler:
  - Counter runs 0..SAMPLE_DIV-1 and wraps to 0.
  - sample_tick is high for the cycle in which the counter equals SAMPLE_DIV-1.
  - With SAMPLE_DIV=1, sample_tick is constantly 1 after reset.
  - Counter width is clog2(SAMPLE_DIV), minimum 1.
- Debounce, per channel, evaluated only on tick cycles:
  - If s_x equals the output: diff counter cleared to 0.
  - Else if diff counter = DEBOUNCE_SAMPLES-1: output takes s_x and counter clears.
  - Else: counter increments.
  - A single matching sample discards the partial count (glitch rejection).
  - Counter never exceeds DEBOUNCE_SAMPLES-1.
- Latency (SAMPLE_DIV=1): a raw edge first captured at edge k appears on the output after edge k+1+DEBOUNCE_SAMPLES.
- change_pulse:
  - Registered; high for exactly the first cycle in which any updated filtered value is visible.
  - Several channels updating on the same tick give one pulse.
- Level fault:
  - invalid = (H & ~M) | (M & ~L), computed on the filtered outputs.
  - FSM states OK, SUSPECT, FAULT, advanced on tick cycles only.
  - OK: invalid → SUSPECT with err counter = 1; if ERR_SAMPLES=1, go directly to FAULT.
  - SUSPECT: invalid → counter+1, and on reaching ERR_SAMPLES → FAULT with counter 0; valid → OK with counter 0.
  - FAULT: valid → counter+1, and on reaching ERR_SAMPLES → OK with counter 0; invalid → counter 0.
  - level_fault is registered and is 1 only while in FAULT.
  - Filtered outputs are never frozen by the fault.
- Reset mid-operation: all state returns to reset values immediately. Outputs restart from 0 and need full debounce again after release.
- Asserting reiniciar for one cycle during FAULT clears level_fault asynchronously.

Test Plan:
1. Reset values: with SAMPLE_DIV=1 and DEBOUNCE_SAMPLES=4, hold reiniciar → all outputs 0. Then drive L_raw=1 captured at edge k → L=1 after edge k+5, change_pulse=1 for one cycle then, H=M=0 throughout.
2. Glitch rejection: with DEBOUNCE_SAMPLES=4, drive Us_raw high for 3 cycles then low → Us stays 0 and change_pulse never asserts. Then hold high for 6 cycles → Us=1.
3. Prescaler: with SAMPLE_DIV=5, sample_tick is high every 5th cycle. With DEBOUNCE_SAMPLES=2, a T_raw step produces T=1 on the tick after the 2nd post-synchroniser sample (≈10-14 cycles), never earlier.
4. Fault entry/exit: with SAMPLE_DIV=1, DEBOUNCE_SAMPLES=1, ERR_SAMPLES=3, force H=1, M=0, L=1 → level_fault=1 after 3 invalid ticks. One valid tick in SUSPECT returns to OK. In FAULT, 2 valid ticks, 1 invalid, then 3 valid → level_fault clears only after the final 3.
5. Simultaneous change: H_raw, M_raw, L_raw rise on the same edge → H, M, L update on the same cycle, exactly one change_pulse, level_fault stays 0.
6. Async reset mid-debounce: reiniciar pulse while counters are partially full and level_fault=1 → outputs 0 within the same cycle with no clk edge. After release, a full DEBOUNCE_SAMPLES sequence is required again.
